// File: rtl/mem_wb_stage.sv
// MEM->WB stage: formats load data from the raw memory word, registers M results into W, muxes writeback.
// Latency: 1 cycle M->W, ResultW is a combinational mux of W registers only. Optional counters: MEMWB_PERF_CNT_EN.
// Backpressure: StallW holds every W register; FlushW (wins over stall) inserts a bubble.
module mem_wb_stage #(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  StallW,
    input  logic                  FlushW,
    input  logic                  ValidM,
    input  logic [31:0]           ReadDataM,
    input  logic [31:0]           ALUResultM,
    input  logic [31:0]           PCPlus4M,
    input  logic [REG_ADDR_W-1:0] RdM,
    input  logic                  RegWriteM,
    input  logic [1:0]            ResultSrcM,
    input  logic [2:0]            LoadTypeM,
    output logic                  ValidW,
    output logic                  RegWriteW,
    output logic [REG_ADDR_W-1:0] RdW,
    output logic [31:0]           ResultW,
    output logic                  LoadMisalignW
`ifdef MEMWB_PERF_CNT_EN
    ,
    output logic [CNT_WIDTH-1:0]  InstRetW,
    output logic [CNT_WIDTH-1:0]  LoadRetW
`endif
);

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam logic [1:0] SRC_ALU  = 2'b00;
    localparam logic [1:0] SRC_LOAD = 2'b01;
    localparam logic [1:0] SRC_PC4  = 2'b10;

    logic [1:0]  byte_off;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_data_m;
    logic        is_load_m;
    logic        misalign_m;
    logic        reg_write_m;

    assign byte_off = ALUResultM[1:0];

    always_comb begin
        byte_sel = ReadDataM[7:0];
        case (byte_off)
            2'd0:    byte_sel = ReadDataM[7:0];
            2'd1:    byte_sel = ReadDataM[15:8];
            2'd2:    byte_sel = ReadDataM[23:16];
            default: byte_sel = ReadDataM[31:24];
        endcase
    end

    assign half_sel = ALUResultM[1] ? ReadDataM[31:16] : ReadDataM[15:0];

    always_comb begin
        load_data_m = 32'h0;
        case (LoadTypeM)
            F3_LB:   load_data_m = {{24{byte_sel[7]}}, byte_sel};
            F3_LBU:  load_data_m = {24'h0, byte_sel};
            F3_LH:   load_data_m = {{16{half_sel[15]}}, half_sel};
            F3_LHU:  load_data_m = {16'h0, half_sel};
            F3_LW:   load_data_m = ReadDataM;
            default: load_data_m = 32'h0;
        endcase
    end

    // Only real loads can be misaligned; bubbles and non-load results never raise the flag.
    assign is_load_m = ValidM && (ResultSrcM == SRC_LOAD);

    always_comb begin
        misalign_m = 1'b0;
        if (is_load_m) begin
            case (LoadTypeM)
                F3_LH, F3_LHU: misalign_m = byte_off[0];
                F3_LW:         misalign_m = (byte_off != 2'b00);
                default:       misalign_m = 1'b0;
            endcase
        end
    end

    assign reg_write_m = RegWriteM && ValidM && (RdM != '0) && !misalign_m;

    logic        valid_w;
    logic        reg_write_w;
    logic        misalign_w;
    logic [REG_ADDR_W-1:0] rd_w;
    logic [1:0]  src_w;
    logic [31:0] alu_w;
    logic [31:0] load_w;
    logic [31:0] pc4_w;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_w     <= 1'b0;
            reg_write_w <= 1'b0;
            misalign_w  <= 1'b0;
            rd_w        <= '0;
            src_w       <= 2'b00;
            alu_w       <= 32'h0;
            load_w      <= 32'h0;
            pc4_w       <= 32'h0;
        end else if (FlushW) begin
            // Control cleared; data registers still load since a bubble never uses them.
            valid_w     <= 1'b0;
            reg_write_w <= 1'b0;
            misalign_w  <= 1'b0;
            rd_w        <= RdM;
            src_w       <= ResultSrcM;
            alu_w       <= ALUResultM;
            load_w      <= load_data_m;
            pc4_w       <= PCPlus4M;
        end else if (!StallW) begin
            valid_w     <= ValidM;
            reg_write_w <= reg_write_m;
            misalign_w  <= misalign_m;
            rd_w        <= RdM;
            src_w       <= ResultSrcM;
            alu_w       <= ALUResultM;
            load_w      <= load_data_m;
            pc4_w       <= PCPlus4M;
        end
    end

    always_comb begin
        ResultW = 32'h0;
        case (src_w)
            SRC_ALU:  ResultW = alu_w;
            SRC_LOAD: ResultW = load_w;
            SRC_PC4:  ResultW = pc4_w;
            default:  ResultW = 32'h0;
        endcase
    end

    assign ValidW        = valid_w;
    assign RegWriteW     = reg_write_w;
    assign RdW           = rd_w;
    assign LoadMisalignW = misalign_w;

`ifdef MEMWB_PERF_CNT_EN
    logic                 capture_m;
    logic                 load_ok_m;
    logic [CNT_WIDTH-1:0] inst_ret_q;
    logic [CNT_WIDTH-1:0] load_ret_q;

    assign capture_m = ValidM && !FlushW && !StallW;
    assign load_ok_m = capture_m && is_load_m && !misalign_m;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inst_ret_q <= '0;
            load_ret_q <= '0;
        end else begin
            if (capture_m) inst_ret_q <= inst_ret_q + 1'b1;
            if (load_ok_m) load_ret_q <= load_ret_q + 1'b1;
        end
    end

    assign InstRetW = inst_ret_q;
    assign LoadRetW = load_ret_q;
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage: load formatting, misalignment, x0 suppression, stall/flush, reset, counters.
module tb_mem_wb_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        StallW, FlushW, ValidM;
    logic [31:0] ReadDataM, ALUResultM, PCPlus4M;
    logic [4:0]  RdM;
    logic        RegWriteM;
    logic [1:0]  ResultSrcM;
    logic [2:0]  LoadTypeM;
    logic        ValidW, RegWriteW, LoadMisalignW;
    logic [4:0]  RdW;
    logic [31:0] ResultW;
`ifdef MEMWB_PERF_CNT_EN
    logic [31:0] InstRetW, LoadRetW;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    mem_wb_stage #(.REG_ADDR_W(5), .CNT_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .StallW(StallW), .FlushW(FlushW), .ValidM(ValidM),
        .ReadDataM(ReadDataM), .ALUResultM(ALUResultM), .PCPlus4M(PCPlus4M), .RdM(RdM),
        .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM), .LoadTypeM(LoadTypeM),
        .ValidW(ValidW), .RegWriteW(RegWriteW), .RdW(RdW), .ResultW(ResultW),
        .LoadMisalignW(LoadMisalignW)
`ifdef MEMWB_PERF_CNT_EN
        , .InstRetW(InstRetW), .LoadRetW(LoadRetW)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] rd_data, input logic [31:0] alu,
                         input logic [31:0] pc4, input logic [4:0] rd, input logic rw,
                         input logic [1:0] src, input logic [2:0] lt);
        ValidM = v; ReadDataM = rd_data; ALUResultM = alu; PCPlus4M = pc4;
        RdM = rd; RegWriteM = rw; ResultSrcM = src; LoadTypeM = lt;
    endtask

    // Advance one rising edge and sample 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"}, 32'(ValidW), 32'h0);
        check({tag, "_regwrite"}, 32'(RegWriteW), 32'h0);
        check({tag, "_rd"}, 32'(RdW), 32'h0);
        check({tag, "_result"}, ResultW, 32'h0);
        check({tag, "_misalign"}, 32'(LoadMisalignW), 32'h0);
`ifdef MEMWB_PERF_CNT_EN
        check({tag, "_instret"}, InstRetW, 32'h0);
        check({tag, "_loadret"}, LoadRetW, 32'h0);
`endif
    endtask

    initial begin
        rst_n = 1'b0; StallW = 1'b0; FlushW = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 2'b00, 3'b000);
        #2;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // LB, offset 3 -> 0x80 sign-extended
        drive(1'b1, 32'h80FF_7F01, 32'h103, 32'h0, 5'd5, 1'b1, 2'b01, 3'b000);
        tick();
        check("lb_off3_result", ResultW, 32'hFFFF_FF80);
        check("lb_off3_regwrite", 32'(RegWriteW), 32'h1);
        check("lb_off3_rd", 32'(RdW), 32'd5);
        check("lb_off3_valid", 32'(ValidW), 32'h1);
        check("lb_off3_misalign", 32'(LoadMisalignW), 32'h0);

        drive(1'b1, 32'h80FF_7F01, 32'h103, 32'h0, 5'd6, 1'b1, 2'b01, 3'b100);
        tick();
        check("lbu_off3_result", ResultW, 32'h0000_0080);
        check("lbu_off3_rd", 32'(RdW), 32'd6);

        drive(1'b1, 32'h80FF_7F01, 32'h101, 32'h0, 5'd6, 1'b1, 2'b01, 3'b000);
        tick();
        check("lb_off1_result", ResultW, 32'h0000_007F);

        drive(1'b1, 32'h80FF_7F01, 32'h102, 32'h0, 5'd6, 1'b1, 2'b01, 3'b000);
        tick();
        check("lb_off2_result", ResultW, 32'hFFFF_FFFF);

        drive(1'b1, 32'h8001_1234, 32'h102, 32'h0, 5'd9, 1'b1, 2'b01, 3'b101);
        tick();
        check("lhu_upper_result", ResultW, 32'h0000_8001);
        check("lhu_upper_misalign", 32'(LoadMisalignW), 32'h0);

        drive(1'b1, 32'h8001_1234, 32'h102, 32'h0, 5'd9, 1'b1, 2'b01, 3'b001);
        tick();
        check("lh_upper_result", ResultW, 32'hFFFF_8001);
        check("lh_upper_regwrite", 32'(RegWriteW), 32'h1);

        drive(1'b1, 32'h8001_1234, 32'h100, 32'h0, 5'd9, 1'b1, 2'b01, 3'b001);
        tick();
        check("lh_lower_result", ResultW, 32'h0000_1234);

        drive(1'b1, 32'h8001_1234, 32'h100, 32'h0, 5'd9, 1'b1, 2'b01, 3'b010);
        tick();
        check("lw_result", ResultW, 32'h8001_1234);

        drive(1'b1, 32'h8001_1234, 32'h100, 32'h0, 5'd9, 1'b1, 2'b01, 3'b011);
        tick();
        check("bad_funct3_result", ResultW, 32'h0);

        drive(1'b1, 32'h8001_1234, 32'h101, 32'h0, 5'd9, 1'b1, 2'b01, 3'b010);
        tick();
        check("lw_mis_misalign", 32'(LoadMisalignW), 32'h1);
        check("lw_mis_regwrite", 32'(RegWriteW), 32'h0);
        check("lw_mis_valid", 32'(ValidW), 32'h1);

        drive(1'b1, 32'h8001_1234, 32'h103, 32'h0, 5'd9, 1'b1, 2'b01, 3'b101);
        tick();
        check("lhu_mis_misalign", 32'(LoadMisalignW), 32'h1);
        check("lhu_mis_regwrite", 32'(RegWriteW), 32'h0);

        drive(1'b0, 32'h8001_1234, 32'h101, 32'h0, 5'd9, 1'b1, 2'b01, 3'b010);
        tick();
        check("bubble_misalign", 32'(LoadMisalignW), 32'h0);
        check("bubble_valid", 32'(ValidW), 32'h0);
        check("bubble_regwrite", 32'(RegWriteW), 32'h0);

        // Misaligned address on a non-load result must not flag
        drive(1'b1, 32'h0, 32'h101, 32'h0, 5'd3, 1'b1, 2'b00, 3'b010);
        tick();
        check("alu_odd_misalign", 32'(LoadMisalignW), 32'h0);
        check("alu_odd_result", ResultW, 32'h101);
        check("alu_odd_regwrite", 32'(RegWriteW), 32'h1);

        drive(1'b1, 32'h0, 32'h55, 32'h0000_0044, 5'd0, 1'b1, 2'b10, 3'b000);
        tick();
        check("x0_pc4_result", ResultW, 32'h44);
        check("x0_pc4_regwrite", 32'(RegWriteW), 32'h0);
        check("x0_pc4_valid", 32'(ValidW), 32'h1);

        drive(1'b1, 32'h1111_1111, 32'h55, 32'h44, 5'd4, 1'b1, 2'b11, 3'b010);
        tick();
        check("src11_result", ResultW, 32'h0);

        drive(1'b1, 32'h0, 32'hDEAD_BEEF, 32'h0, 5'd7, 1'b1, 2'b00, 3'b000);
        tick();
        check("capture_result", ResultW, 32'hDEAD_BEEF);
        check("capture_rd", 32'(RdW), 32'd7);

        StallW = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h0, 32'h1000 + 32'(i), 32'h0, 5'(10 + i), 1'b0, 2'b00, 3'b000);
            tick();
            check("stall_result", ResultW, 32'hDEAD_BEEF);
            check("stall_rd", 32'(RdW), 32'd7);
            check("stall_regwrite", 32'(RegWriteW), 32'h1);
        end

        FlushW = 1'b1;
        tick();
        check("flush_stall_valid", 32'(ValidW), 32'h0);
        check("flush_stall_regwrite", 32'(RegWriteW), 32'h0);
        check("flush_stall_misalign", 32'(LoadMisalignW), 32'h0);
        StallW = 1'b0; FlushW = 1'b0;

        // Put a valid write in W, then reset mid-cycle and look before any edge
        drive(1'b1, 32'h0, 32'h1234_5678, 32'h0, 5'd8, 1'b1, 2'b00, 3'b000);
        tick();
        check("pre_reset_valid", 32'(ValidW), 32'h1);
        #3 rst_n = 1'b0;
        #1 check_all_zero("midcycle_reset1");
        @(negedge clk);
        rst_n = 1'b1;

        // 4 captured instructions: aligned LW, aligned LBU, misaligned LH, ALU
        drive(1'b1, 32'hA5A5_5A5A, 32'h200, 32'h0, 5'd1, 1'b1, 2'b01, 3'b010);
        tick();
        check("cnt_lw_result", ResultW, 32'hA5A5_5A5A);
        drive(1'b1, 32'hA5A5_5A5A, 32'h203, 32'h0, 5'd2, 1'b1, 2'b01, 3'b100);
        tick();
        check("cnt_lbu_result", ResultW, 32'h0000_00A5);
        drive(1'b1, 32'hA5A5_5A5A, 32'h201, 32'h0, 5'd3, 1'b1, 2'b01, 3'b001);
        tick();
        check("cnt_lh_mis", 32'(LoadMisalignW), 32'h1);
        drive(1'b1, 32'h0, 32'h77, 32'h0, 5'd4, 1'b1, 2'b00, 3'b000);
        tick();
        check("cnt_alu_result", ResultW, 32'h77);
        // Extra cycles: a flushed load, a stalled load, a bubble -- none count
        drive(1'b1, 32'hA5A5_5A5A, 32'h200, 32'h0, 5'd5, 1'b1, 2'b01, 3'b010);
        FlushW = 1'b1;
        tick();
        check("cnt_flush_valid", 32'(ValidW), 32'h0);
        FlushW = 1'b0; StallW = 1'b1;
        tick();
        check("cnt_stall_valid", 32'(ValidW), 32'h0);
        StallW = 1'b0;
        drive(1'b0, 32'hA5A5_5A5A, 32'h200, 32'h0, 5'd5, 1'b1, 2'b01, 3'b010);
        tick();
        check("cnt_bubble_valid", 32'(ValidW), 32'h0);
`ifdef MEMWB_PERF_CNT_EN
        check("instret_count", InstRetW, 32'd4);
        check("loadret_count", LoadRetW, 32'd2);
`endif

        drive(1'b1, 32'h0, 32'hCAFE_0000, 32'h0, 5'd12, 1'b1, 2'b00, 3'b000);
        tick();
        #2 rst_n = 1'b0;
        #1 check_all_zero("midcycle_reset2");
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

endmodule
